// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_deserializer
// Description : MSB-first serial-to-parallel converter with a one-word output
//               holding register, ready/valid handshake, sticky overrun flag
//               and synchronous abort of a partial word.
//               Optional feature macro: PARITY_CHECK_EN -- each word carries
//               one trailing even-parity bit and parity_err reports its check.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_deserializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         serial_in,
  input  logic         serial_valid,
  input  logic         abort,
  input  logic         out_ready,
  input  logic         clr_overrun,
  output logic [N-1:0] parallel_out,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  // Counter must reach N when the parity state is present.
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef PARITY_CHECK_EN
    PAR   = 2'd2,
`endif
    SHIFT = 2'd1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic [N-1:0]   shreg;
  logic [N-1:0]   shreg_nxt;
  logic           done;      // a complete word is available on this edge
  logic [N-1:0]   word;      // the completed word (valid when done=1)
  logic           drop;      // completion while the holding register is full
`ifdef PARITY_CHECK_EN
  logic           word_par;  // XOR of data bits and parity bit
`endif

  // State, bit count and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Next-state logic: abort has priority over an accepted bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    done      = 1'b0;
    word      = shreg;
`ifdef PARITY_CHECK_EN
    word_par  = 1'b0;
`endif
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      shreg_nxt = '0;
    end else if (serial_valid) begin
      case (state)
        IDLE: begin
          shreg_nxt = {shreg[N-2:0], serial_in};
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
        SHIFT: begin
          shreg_nxt = {shreg[N-2:0], serial_in};
          if (cnt == CW'(N - 1)) begin
`ifdef PARITY_CHECK_EN
            // All data bits held; the next accepted bit is parity.
            state_nxt = PAR;
            cnt_nxt   = CW'(N);
`else
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done      = 1'b1;
            word      = {shreg[N-2:0], serial_in};
`endif
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PAR: begin
          // Parity bit is not shifted into the data register.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done      = 1'b1;
          word      = shreg;
          word_par  = ^{shreg, serial_in};
        end
`endif
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign drop = done & out_valid & ~out_ready;
  assign busy = (state != IDLE);

  // Output holding register with ready/valid handshake and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (done) begin
        if (!out_valid || out_ready) begin
          parallel_out <= word;
          out_valid    <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity status travels with the word it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (done && (!out_valid || out_ready)) begin
      parity_err <= word_par;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_deserializer
// Description : Self-checking bench for serial_deserializer (N=4). Directed
//               scenarios plus randomized traffic compared every cycle with a
//               queue-based word-level reference model.
//               Honours PARITY_CHECK_EN when defined at build time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_deserializer;

  localparam int N = 4;
`ifdef PARITY_CHECK_EN
  localparam int WL = N + 1;
`else
  localparam int WL = N;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         serial_in = 1'b0;
  logic         serial_valid = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr_overrun = 1'b0;
  logic [N-1:0] parallel_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: bits of the word in flight plus the output slot.
  bit           pend[$];
  bit           m_valid = 1'b0;
  bit           m_over  = 1'b0;
  bit           m_perr  = 1'b0;
  logic [N-1:0] m_data  = '0;

  serial_deserializer #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .abort        (abort),
    .out_ready    (out_ready),
    .clr_overrun  (clr_overrun),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_perr  = 1'b0;
    m_data  = '0;
  endtask

  // One rising edge of the reference model, from the word-level rules.
  task automatic model_edge(input bit sv, input bit si, input bit ab, input bit rdy, input bit clr);
    bit           done = 1'b0;
    bit           drop = 1'b0;
    bit           p = 1'b0;
    logic [N-1:0] w = '0;
    if (ab) begin
      pend.delete();
    end else if (sv) begin
      pend.push_back(si);
      if (pend.size() == WL) begin
        foreach (pend[i]) begin
          if (i < N) w = {w[N-2:0], pend[i]};
          p ^= pend[i];
        end
        done = 1'b1;
        pend.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = w;
        m_valid = 1'b1;
        m_perr  = (WL > N) ? p : 1'b0;
      end else begin
        drop = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (drop) m_over = 1'b1;
    else if (clr) m_over = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"},   out_valid,    m_valid);
    check({tag, ".data"},    parallel_out, m_data);
    check({tag, ".busy"},    busy,         pend.size() != 0);
    check({tag, ".overrun"}, overrun,      m_over);
    check({tag, ".perr"},    parity_err,   m_perr);
  endtask

  // Drive one cycle of inputs, advance one edge, compare with the model.
  task automatic step(input bit sv, input bit si, input bit ab, input bit rdy, input bit clr);
    serial_valid = sv;
    serial_in    = si;
    abort        = ab;
    out_ready    = rdy;
    clr_overrun  = clr;
    model_edge(sv, si, ab, rdy, clr);
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rst");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    serial_valid = 1'b0;
    abort        = 1'b0;
    clr_overrun  = 1'b0;
  endtask

  // Send one word MSB first (plus correct parity when enabled); out_ready is
  // rdy_body on all bits but the last, rdy_last on the last one.
  task automatic send_word(input logic [N-1:0] w, input bit rdy_body, input bit rdy_last,
                           input bit gap_chk);
    for (int i = 0; i < WL; i++) begin
      bit b;
      b = (i < N) ? w[N-1-i] : ^w;
      step(1'b1, b, 1'b0, (i == WL - 1) ? rdy_last : rdy_body, 1'b0);
      if (gap_chk) check("nogap.valid", out_valid, 1'b1);
    end
  endtask

  initial begin
    #1;
    do_reset();
    check("reset.data", parallel_out, 4'b0000);

    // Single word with consumer ready, then consumption.
    send_word(4'b1011, 1'b1, 1'b1, 1'b0);
    check("w1.valid", out_valid, 1'b1);
    check("w1.data", parallel_out, 4'b1011);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("w1.consumed", out_valid, 1'b0);

    // Overrun: second word dropped while the first is held.
    send_word(4'b1011, 1'b0, 1'b0, 1'b0);
    send_word(4'b0110, 1'b0, 1'b0, 1'b0);
    check("ovr.data", parallel_out, 4'b1011);
    check("ovr.flag", overrun, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr.clr", overrun, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back words; load on a consuming edge leaves no valid gap.
    send_word(4'b1011, 1'b1, 1'b1, 1'b0);
    check("b2b.first", parallel_out, 4'b1011);
    send_word(4'b0110, 1'b0, 1'b1, 1'b1);
    check("b2b.second", parallel_out, 4'b0110);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort wins over a simultaneous bit and discards the partial word.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("abort.busy", busy, 1'b0);
    send_word(4'b0110, 1'b1, 1'b1, 1'b0);
    check("abort.data", parallel_out, 4'b0110);
    check("abort.idle", busy, 1'b0);

    // Asynchronous reset between edges in the middle of a word.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.data", parallel_out, 4'b0000);
    check("arst.valid", out_valid, 1'b0);
    check("arst.busy", busy, 1'b0);
    check("arst.ovr", overrun, 1'b0);
    check("arst.perr", parity_err, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(4'b1001, 1'b1, 1'b1, 1'b0);
    check("arst.word", parallel_out, 4'b1001);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PARITY_CHECK_EN
    // Correct and incorrect even parity on the same data.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("par.ok", parity_err, 1'b0);
    check("par.ok.data", parallel_out, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("par.bad", parity_err, 1'b1);
`endif

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
